mul_div_sequencer: RTL and testbench
====================================

# mul_div_sequencer

Multi-cycle unsigned multiply/divide engine and stall controller for the EX stage of the pipelined MIPS core. It starts when the EX-stage ALU control code selects multiplication (4'b1100) or division (4'b1110). It then freezes the pipeline through the stall line, runs a WIDTH-iteration shift-add multiply or restoring divide, and returns a double-width result with a one-cycle done pulse. All other ALU codes bypass it and go to the single-cycle ALU.

## Interface
Parameters:
- WIDTH, 16, operand width; the iteration counter is $clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  rising-edge clock; the block uses one clock.
- rstN  in  1  reset, asynchronous and active-low.
- start  in  1  EX-stage instruction is valid.
- aluCnt  in  4  ALU control code from ALU_Control. 4'b1100 selects multiply, 4'b1110 selects divide. Any other code means the block ignores start.
- opA  in  WIDTH  multiplicand or dividend.
- opB  in  WIDTH  multiplier or divisor.
- flush  in  1  pipeline flush; aborts the operation in progress.
- stall  out  1  freezes the IF, ID and EX stages. Combinational from the state and the inputs.
- done  out  1  one-cycle pulse; the results are valid.
- resLo  out  WIDTH  product bits [WIDTH-1:0], or the quotient.
- resHi  out  WIDTH  product bits [2*WIDTH-1:WIDTH], or the remainder.
- divZero  out  1  the last division had opB == 0. Held with the results.

## Operation
- States:
  - IDLE: waits for an accepted start.
  - MUL: shift-add multiply iterations.
  - DIV: restoring divide iterations.
  - DONE: presents the results for one cycle.
- Accept condition: state IDLE, start=1, aluCnt in {1100, 1110}, flush=0.
- On accept:
  - Latch opA and opB.
  - Clear the accumulator.
  - Load the counter with WIDTH.
  - Go to MUL or DIV.
- Exception: divide with opB==0 goes straight to DONE with no iterations.
- MUL, one iteration per cycle, unsigned: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half. Then shift {carry, acc, multiplier} right by 1.
- DIV, one iteration per cycle, unsigned restoring: shift {rem, quotient} left by 1. Compute the trial value rem - divisor, which is WIDTH+1 bits wide. If it is non-negative, the remainder takes the trial value and the quotient LSB is set to 1.
- The counter decrements once per iteration. When it reaches 0, the state goes to DONE.
- DONE:
  - resLo, resHi and divZero update on entry to DONE and hold until the next completion.
  - done=1 for exactly that cycle.
  - The next state is always IDLE. start is ignored in DONE, because the same instruction is still in EX.
- Divide by zero: resLo=all ones, resHi=opA, divZero=1.
- A completed multiply, or a divide with a nonzero divisor, clears divZero.
- flush has priority in every state:
  - Next state is IDLE.
  - No done pulse.
  - resLo, resHi and divZero keep their previous values.
  - stall=0 in any cycle where flush=1.
- stall = !flush && ((IDLE && accept condition) || MUL || DIV).
- stall is 0 in DONE, so the pipeline advances with the valid result that cycle.
- Reset, asynchronous and valid at any time (including mid-operation):
  - state=IDLE; counter, accumulator and operands = 0.
  - resLo=0, resHi=0, divZero=0, done=0.
  - stall=0 for as long as start=0.

## Timing
- Cycle 0: the accept edge; stall=1 in this cycle.
- Cycles 1..WIDTH: iterations, with stall=1.
- Cycle WIDTH+1: DONE, with done=1 and stall=0.
- Latency from accept to done is WIDTH+1 cycles; the stall duration is WIDTH+1 cycles.
- Divide by zero: done in cycle 1; stall only in cycle 0.
- Back-to-back operations: a second mul/div arriving in EX the cycle after DONE is accepted from IDLE. That gives one bubble-free result every WIDTH+2 cycles.
- opA, opB and aluCnt are only sampled on the accept edge. Changes during MUL or DIV have no effect.

## Test plan
- Multiply: WIDTH=16, opA=300, opB=250, aluCnt=1100. Stall high for cycles 0-16. done in cycle 17 with resHi=16'h0001, resLo=16'h24F8, divZero=0.
- Multiply worst case: opA=opB=16'hFFFF gives resHi=16'hFFFE, resLo=16'h0001. Then 16'h1234*0 gives both results 0.
- Divide: opA=1000, opB=7, aluCnt=1110 gives resLo=142, resHi=6, done in cycle 17. Repeat with opA=5, opB=9, which gives resLo=0, resHi=5.
- Divide by zero: opA=16'h1234, opB=0. done in cycle 1 with resLo=16'hFFFF, resHi=16'h1234, divZero=1. A following multiply clears divZero.
- Flush at cycle 5 of a multiply: stall drops in that cycle and no done pulse follows. Results keep their previous values. A new divide accepted afterward completes correctly.
- rstN low at cycle 8 of a divide: all outputs go to 0 immediately. Non-mul/div aluCnt (0000) with start=1 never raises stall. start held high through DONE does not relaunch.

Source files
------------

// File: rtl/mul_div_sequencer.sv
// Multi-cycle unsigned shift-add multiplier / restoring divider for the EX stage.
// Freezes IF/ID/EX through stall while iterating and presents a double-width result with a done pulse.
module mul_div_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [3:0]       aluCnt,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] resLo,
  output logic [WIDTH-1:0] resHi,
  output logic             divZero
);

  localparam int         CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [3:0] ALU_MUL = 4'b1100;
  localparam logic [3:0] ALU_DIV = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q;         // multiplicand or divisor
  logic [WIDTH-1:0]   acc_q, acc_d;   // upper product half or partial remainder
  logic [WIDTH-1:0]   shr_q, shr_d;   // multiplier shifting into low product, or dividend into quotient
  logic [WIDTH-1:0]   res_lo_q, res_hi_q;
  logic               div_zero_q;
  logic               done_q;

  logic               is_mul, is_div, accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     trial;

  always_comb begin
    is_mul = (aluCnt == ALU_MUL);
    is_div = (aluCnt == ALU_DIV);
    accept = (state_q == S_IDLE) && start && (is_mul || is_div) && !flush;
    stall  = !flush && (accept || (state_q == S_MUL) || (state_q == S_DIV));
  end

  // One iteration of either algorithm; the carry of the add rides in mul_sum[WIDTH].
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_shift = {acc_q, shr_q[WIDTH-1]};
    trial     = rem_shift - {1'b0, opnd_q};
    acc_d     = acc_q;
    shr_d     = shr_q;
    cnt_d     = cnt_q - CNT_W'(1);
    if (state_q == S_MUL) begin
      acc_d = mul_sum[WIDTH:1];
      shr_d = {mul_sum[0], shr_q[WIDTH-1:1]};
    end else if (state_q == S_DIV) begin
      // rem_shift < 2*divisor, so the top bit of trial is a valid borrow flag.
      acc_d = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
      shr_d = {shr_q[WIDTH-2:0], ~trial[WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      shr_q      <= '0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              opnd_q <= opB;
              shr_q  <= opA;
              acc_q  <= '0;
              cnt_q  <= CNT_W'(WIDTH);
              if (is_div && (opB == '0)) begin
                state_q    <= S_DONE;
                res_lo_q   <= '1;
                res_hi_q   <= opA;
                div_zero_q <= 1'b1;
                done_q     <= 1'b1;
              end else begin
                state_q <= is_mul ? S_MUL : S_DIV;
              end
            end
          end
          S_MUL, S_DIV: begin
            acc_q <= acc_d;
            shr_q <= shr_d;
            cnt_q <= cnt_d;
            // Both algorithms finish with {acc, shr} = {high/remainder, low/quotient}.
            if (cnt_d == '0) begin
              state_q    <= S_DONE;
              res_lo_q   <= shr_d;
              res_hi_q   <= acc_d;
              div_zero_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign done    = done_q;
  assign resLo   = res_lo_q;
  assign resHi   = res_hi_q;
  assign divZero = div_zero_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Randomised self-checking bench for mul_div_sequencer against an arithmetic reference model.
module tb_mul_div_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstN, start, flush;
  logic [3:0]   aluCnt;
  logic [W-1:0] opA, opB;
  logic         stall, done, divZero;
  logic [W-1:0] resLo, resHi;

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] prev_lo, prev_hi;
  logic         prev_dz;

  mul_div_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rstN(rstN), .start(start), .aluCnt(aluCnt), .opA(opA), .opB(opB),
    .flush(flush), .stall(stall), .done(done), .resLo(resLo), .resHi(resHi), .divZero(divZero)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit is_div,
                                output logic [W-1:0] lo, output logic [W-1:0] hi,
                                output logic dz, output int lat);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    if (!is_div) begin
      lo = p[W-1:0]; hi = p[2*W-1:W]; dz = 1'b0; lat = W + 1;
    end else if (b == 0) begin
      lo = {W{1'b1}}; hi = a; dz = 1'b1; lat = 1;
    end else begin
      lo = a / b; hi = a % b; dz = 1'b0; lat = W + 1;
    end
  endfunction

  // Drives one operation from IDLE, returns in the cycle after done (or after a timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit is_div, input bit hold,
                        output int lat, output int serr,
                        output logic [W-1:0] lo, output logic [W-1:0] hi, output logic dz);
    lat = -1; serr = 0; lo = '0; hi = '0; dz = 1'b0;
    start = 1'b1; aluCnt = is_div ? 4'b1110 : 4'b1100; opA = a; opB = b;
    #1;
    if (stall !== 1'b1) serr++;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      cyc();
      if (!hold) begin
        start = 1'b0; aluCnt = 4'($urandom);
      end
      opA = W'($urandom); opB = W'($urandom);
      #1;
      if (done === 1'b1) begin
        lat = c; lo = resLo; hi = resHi; dz = divZero;
        if (stall !== 1'b0) serr++;
      end else if (stall !== 1'b1) begin
        serr++;
      end
    end
    cyc();
    start = 1'b0; aluCnt = 4'b0000;
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b0; flush = 1'b0; aluCnt = 4'b0000; opA = '0; opB = '0;
    repeat (2) @(posedge clk);
    #2;
    n_vec++; if (resLo !== '0) begin n_bad++; $display("FAIL reset_lo got %h exp 0000", resLo); end
    n_vec++; if (resHi !== '0) begin n_bad++; $display("FAIL reset_hi got %h exp 0000", resHi); end
    n_vec++; if (divZero !== 1'b0) begin n_bad++; $display("FAIL reset_dz got %b exp 0", divZero); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b exp 0", stall); end
    @(negedge clk) rstN = 1'b1;
    cyc();
    prev_lo = '0; prev_hi = '0; prev_dz = 1'b0;
  endtask

  task automatic test_mul();
    logic [W-1:0] av[3] = '{16'd300, 16'hFFFF, 16'h1234};
    logic [W-1:0] bv[3] = '{16'd250, 16'hFFFF, 16'h0000};
    int lat, serr, elat;
    logic [W-1:0] lo, hi, elo, ehi;
    logic dz, edz;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], 1'b0, 1'b0, lat, serr, lo, hi, dz);
      model(av[i], bv[i], 1'b0, elo, ehi, edz, elat);
      n_vec++; if (lat !== elat) begin n_bad++; $display("FAIL mul_latency a=%h b=%h got %0d exp %0d", av[i], bv[i], lat, elat); end
      n_vec++; if (serr != 0) begin n_bad++; $display("FAIL mul_stall a=%h b=%h got %0d bad cycles exp 0", av[i], bv[i], serr); end
      n_vec++; if ({hi, lo, dz} !== {ehi, elo, edz}) begin
        n_bad++; $display("FAIL mul_result a=%h b=%h got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b", av[i], bv[i], hi, lo, dz, ehi, elo, edz);
      end
      prev_lo = elo; prev_hi = ehi; prev_dz = edz;
    end
  endtask

  task automatic test_div();
    logic [W-1:0] av[4] = '{16'd1000, 16'd5, 16'hFFFF, 16'h1234};
    logic [W-1:0] bv[4] = '{16'd7, 16'd9, 16'hFFFF, 16'h0000};
    int lat, serr, elat;
    logic [W-1:0] lo, hi, elo, ehi;
    logic dz, edz;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], 1'b1, 1'b0, lat, serr, lo, hi, dz);
      model(av[i], bv[i], 1'b1, elo, ehi, edz, elat);
      n_vec++; if (lat !== elat) begin n_bad++; $display("FAIL div_latency a=%h b=%h got %0d exp %0d", av[i], bv[i], lat, elat); end
      n_vec++; if (serr != 0) begin n_bad++; $display("FAIL div_stall a=%h b=%h got %0d bad cycles exp 0", av[i], bv[i], serr); end
      n_vec++; if ({hi, lo, dz} !== {ehi, elo, edz}) begin
        n_bad++; $display("FAIL div_result a=%h b=%h got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b", av[i], bv[i], hi, lo, dz, ehi, elo, edz);
      end
      prev_lo = elo; prev_hi = ehi; prev_dz = edz;
    end
    // divZero is held after completion, then cleared by a following multiply
    n_vec++; if (divZero !== 1'b1) begin n_bad++; $display("FAIL divzero_held got %b exp 1", divZero); end
    run_op(16'd3, 16'd5, 1'b0, 1'b0, lat, serr, lo, hi, dz);
    n_vec++; if ({hi, lo, dz} !== {16'd0, 16'd15, 1'b0}) begin
      n_bad++; $display("FAIL divzero_clear got hi=%h lo=%h dz=%b exp hi=0000 lo=000f dz=0", hi, lo, dz);
    end
    prev_lo = 16'd15; prev_hi = '0; prev_dz = 1'b0;
  endtask

  task automatic test_flush();
    int bad;
    int lat, serr, elat;
    logic [W-1:0] lo, hi, elo, ehi, a, b;
    logic dz, edz;
    start = 1'b1; aluCnt = 4'b1100; opA = W'($urandom); opB = W'($urandom);
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    flush = 1'b1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b exp 0", stall); end
    cyc();
    flush = 1'b0;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (done !== 1'b0 || stall !== 1'b0) bad++;
      cyc();
    end
    n_vec++; if (bad != 0) begin n_bad++; $display("FAIL flush_no_done got %0d busy cycles exp 0", bad); end
    n_vec++; if ({resHi, resLo, divZero} !== {prev_hi, prev_lo, prev_dz}) begin
      n_bad++; $display("FAIL flush_hold got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b", resHi, resLo, divZero, prev_hi, prev_lo, prev_dz);
    end
    a = W'($urandom); b = W'($urandom_range(1, 65535));
    run_op(a, b, 1'b1, 1'b0, lat, serr, lo, hi, dz);
    model(a, b, 1'b1, elo, ehi, edz, elat);
    n_vec++; if (lat !== elat || {hi, lo, dz} !== {ehi, elo, edz}) begin
      n_bad++; $display("FAIL flush_recover a=%h b=%h got lat=%0d hi=%h lo=%h exp lat=%0d hi=%h lo=%h", a, b, lat, hi, lo, elat, ehi, elo);
    end
    prev_lo = elo; prev_hi = ehi; prev_dz = edz;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; aluCnt = 4'b1110; opA = 16'd1000; opB = 16'd7;
    cyc();
    start = 1'b0;
    repeat (7) cyc();
    rstN = 1'b0;
    #1;
    n_vec++; if ({resHi, resLo, divZero, done, stall} !== {(2*W+3){1'b0}}) begin
      n_bad++; $display("FAIL reset_mid got hi=%h lo=%h dz=%b done=%b stall=%b exp all 0", resHi, resLo, divZero, done, stall);
    end
    @(negedge clk) rstN = 1'b1;
    cyc();
    prev_lo = '0; prev_hi = '0; prev_dz = 1'b0;
  endtask

  task automatic test_bypass();
    int bad;
    int lat, serr;
    logic [W-1:0] lo, hi;
    logic dz;
    bad = 0;
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      aluCnt = (c == 0) ? 4'b0000 : 4'($urandom);
      if (aluCnt == 4'b1100 || aluCnt == 4'b1110) aluCnt = 4'b0000;
      opA = W'($urandom); opB = W'($urandom);
      #1;
      if (stall !== 1'b0 || done !== 1'b0) bad++;
      cyc();
    end
    start = 1'b0; aluCnt = 4'b0000;
    n_vec++; if (bad != 0) begin n_bad++; $display("FAIL bypass got %0d busy cycles exp 0", bad); end
    // start held high through DONE must not relaunch
    run_op(16'd12, 16'd13, 1'b0, 1'b1, lat, serr, lo, hi, dz);
    n_vec++; if (lat !== W + 1 || {hi, lo} !== 32'd156) begin
      n_bad++; $display("FAIL hold_start_result got lat=%0d hi=%h lo=%h exp lat=%0d hi=0000 lo=009c", lat, hi, lo, W + 1);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall !== 1'b0 || done !== 1'b0) bad++;
      cyc();
    end
    n_vec++; if (bad != 0) begin n_bad++; $display("FAIL hold_start_relaunch got %0d busy cycles exp 0", bad); end
    prev_lo = 16'd156; prev_hi = '0; prev_dz = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, serr, elat;
    logic [W-1:0] lo, hi, elo, ehi, a, b;
    logic dz, edz;
    bit d;
    for (int i = 0; i < 24; i++) begin
      d = 1'($urandom);
      a = W'($urandom);
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      run_op(a, b, d, 1'b0, lat, serr, lo, hi, dz);
      model(a, b, d, elo, ehi, edz, elat);
      n_vec++; if (lat !== elat || serr != 0) begin
        n_bad++; $display("FAIL b2b_timing op=%0d div=%b a=%h b=%h got lat=%0d stallerr=%0d exp lat=%0d stallerr=0", i, d, a, b, lat, serr, elat);
      end
      n_vec++; if ({hi, lo, dz} !== {ehi, elo, edz}) begin
        n_bad++; $display("FAIL b2b_result op=%0d div=%b a=%h b=%h got hi=%h lo=%h dz=%b exp hi=%h lo=%h dz=%b", i, d, a, b, hi, lo, dz, ehi, elo, edz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_reset_mid();
    test_bypass();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
